fifo_stream_reader: RTL and testbench
=====================================

// Module: fifo_stream_reader
// PURPOSE
//  Read-side master for the synchronous FIFO: drives rd_en, absorbs the FIFO's 1-cycle registered read
//  latency and re-presents words as a valid/ready stream to a downstream consumer.
//  Never issues a read on an empty FIFO, so the FIFO never underflows. Words leave in FIFO order, with no
//  drops or duplicates, at up to 1 word/cycle. Sits between the FIFO read port and the downstream datapath.
// PARAMETERS
//  DATA_WIDTH  16  word width; must equal FIFO_WIDTH of the attached FIFO
//  BUF_DEPTH   3   skid-buffer entries; minimum 3 (needed for full throughput with no m_ready->rd_en path)
// PORTS
//  clk            in   1           clock, rising edge
//  rst_n          in   1           reset, asynchronous, active-low
//  run            in   1           1 = fetch from FIFO; 0 = stop fetching and drain
//  fifo_empty     in   1           FIFO empty flag
//  fifo_data_out  in   DATA_WIDTH  FIFO read data, valid the cycle after rd_en on a non-empty FIFO
//  fifo_underflow in   1           FIFO underflow flag
//  fifo_rd_en     out  1           FIFO read request
//  m_valid        out  1           stream word valid
//  m_ready        in   1           stream consumer ready
//  m_data         out  DATA_WIDTH  stream word
//  busy           out  1           state != IDLE
//  underflow_err  out  1           sticky protocol-error flag
// BEHAVIOUR
//  Reset (async): state=IDLE, occ=0, inflight=0, head=tail=0, buffer=0.
//   Resulting outputs: fifo_rd_en=0, m_valid=0, m_data=0, busy=0, underflow_err=0.
//   An in-flight read at reset is discarded.
//  FSM (registered):
//   IDLE  -> RUN when run=1.
//   RUN   -> DRAIN when run=0.
//   DRAIN -> RUN when run=1.
//   DRAIN -> IDLE when run=0 && inflight=0 && occ=0.
//  fifo_rd_en = (state==RUN) && !fifo_empty && (occ + inflight < BUF_DEPTH).
//   Combinational from registered state and fifo_empty only; there is no m_ready-to-rd_en path.
//  inflight <= fifo_rd_en.
//   When inflight=1, fifo_data_out is written at tail and tail advances, wrapping at BUF_DEPTH-1 -> 0.
//  pop = m_valid && m_ready; head advances on pop, wrapping the same way.
//  occ <= occ + inflight - pop (push and pop in the same cycle: occ unchanged). occ never exceeds BUF_DEPTH.
//  m_valid = (occ != 0); m_data = buffer[head].
//   m_data is stable while m_valid && !m_ready; m_valid never drops without a pop.
//  Latency: a word read at edge N appears on m_data after edge N+1 (FIFO rd_en to m_valid = 2 clocks).
//   First m_valid comes 3 clocks after run is first sampled high.
//  Throughput: 1 word/cycle sustained when the FIFO is non-empty and m_ready=1.
//  run falling: no new reads; the in-flight word is still captured; buffered words still delivered.
//  underflow_err: set when fifo_underflow=1 is sampled; cleared only by rst_n.
//  Internal widths: occ is $clog2(BUF_DEPTH+1) bits; head and tail are $clog2(BUF_DEPTH) bits.
// CONFIGURATION
//  FIFO_READER_STATS_EN defined: adds two ports.
//   beat_cnt  out 16: increments on each pop.
//   stall_cnt out 16: increments each cycle with m_valid && !m_ready.
//   Both saturate at 16'hFFFF and reset to 0.
//  FIFO_READER_STATS_EN undefined: both ports and their logic are absent; all other behaviour is identical.
// TESTING
//  1 Reset: rst_n=0 mid-stream with occ=2.
//    -> m_valid, fifo_rd_en, busy, underflow_err drop to 0 immediately (async); m_data=0.
//  2 FIFO preloaded 16'h0001..16'h0008, run=1, m_ready=1.
//    -> fifo_rd_en high exactly 8 cycles; m_data 16'h0001..16'h0008 on 8 consecutive cycles.
//    -> fifo_underflow never 1.
//  3 Same preload, m_ready=0.
//    -> fifo_rd_en pulses exactly 3 times, then stays 0; m_data held at 16'h0001.
//    -> stall_cnt counts (STATS_EN). Then m_ready=1 -> 16'h0001..16'h0008 in order; beat_cnt=8.
//  4 run dropped on the cycle of the 4th fifo_rd_en.
//    -> no 5th read; words 16'h0001..16'h0004 delivered; busy=1 until the last pop; then state IDLE.
//  5 run=1, fifo_empty=1 for 20 cycles -> fifo_rd_en never 1.
//    Then fifo_underflow forced 1 for one cycle -> underflow_err=1 and stays 1 until rst_n.
//  6 FIFO toggling empty/non-empty every cycle, random m_ready for 1000 cycles.
//    -> output sequence equals FIFO write order; fifo_rd_en never 1 while fifo_empty=1.

Source files
------------

// File: rtl/fifo_stream_reader_if.sv
// Purpose: bundles the FIFO read port and the downstream valid/ready stream.
//   master : the stream reader (drives fifo_rd_en, m_valid, m_data)
//   slave  : the environment (FIFO read side and the stream consumer)
// Signals:
//   fifo_empty, fifo_data_out, fifo_underflow : from FIFO
//   fifo_rd_en                                : to FIFO
//   m_valid, m_data                           : stream word to consumer
//   m_ready                                   : consumer ready
interface fifo_stream_reader_if #(
    parameter int unsigned DATA_WIDTH = 16
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data_out;
    logic                  fifo_underflow;
    logic                  fifo_rd_en;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;

    modport master (
        input  fifo_empty,
        input  fifo_data_out,
        input  fifo_underflow,
        input  m_ready,
        output fifo_rd_en,
        output m_valid,
        output m_data
    );

    modport slave (
        output fifo_empty,
        output fifo_data_out,
        output fifo_underflow,
        output m_ready,
        input  fifo_rd_en,
        input  m_valid,
        input  m_data
    );
endinterface

// File: rtl/fifo_stream_reader.sv
// Purpose: read-side master for a synchronous FIFO. Issues rd_en only when the
// FIFO is non-empty and the skid buffer has room for every outstanding word,
// absorbs the FIFO's 1-cycle read latency and re-presents words in order as a
// valid/ready stream at up to one word per cycle.
// Ports:
//   clk, rst_n      : clock (rising edge), asynchronous active-low reset
//   run             : 1 = fetch from FIFO, 0 = stop fetching and drain
//   bus (master)    : FIFO read port + downstream stream (see interface)
//   busy            : controller not idle
//   underflow_err   : sticky, set when the FIFO reports underflow
//   beat_cnt        : (FIFO_READER_STATS_EN) saturating count of stream pops
//   stall_cnt       : (FIFO_READER_STATS_EN) saturating count of stalled cycles
// Optional feature: define FIFO_READER_STATS_EN to add the statistic counters.
module fifo_stream_reader #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned BUF_DEPTH  = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       run,
    fifo_stream_reader_if.master       bus,
    output logic                       busy,
    output logic                       underflow_err
`ifdef FIFO_READER_STATS_EN
    ,
    output logic [15:0]                beat_cnt,
    output logic [15:0]                stall_cnt
`endif
);

    localparam int unsigned OCC_W = $clog2(BUF_DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(BUF_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [OCC_W-1:0]      occ;
    logic                  inflight;
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [DATA_WIDTH-1:0] buffer [BUF_DEPTH];
    logic                  rd_en_c;
    logic                  pop_c;
    logic [OCC_W:0]        fill_c;

    // Circular pointer increment over BUF_DEPTH entries.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Words buffered plus the one possibly returning from the FIFO.
    assign fill_c = (OCC_W + 1)'(occ) + (OCC_W + 1)'(inflight);
    assign pop_c  = bus.m_valid && bus.m_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (run) state_d = RUN;
            RUN:     if (!run) state_d = DRAIN;
            DRAIN: begin
                if (run) begin
                    state_d = RUN;
                end else if (!inflight && (occ == '0)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: read request depends only on registered state and fifo_empty,
    // so the consumer's ready never reaches the FIFO read port combinationally.
    always_comb begin
        rd_en_c = 1'b0;
        busy    = 1'b0;
        if (state_q != IDLE) begin
            busy = 1'b1;
        end
        if ((state_q == RUN) && !bus.fifo_empty && (fill_c < (OCC_W + 1)'(BUF_DEPTH))) begin
            rd_en_c = 1'b1;
        end
    end

    assign bus.fifo_rd_en = rd_en_c;
    assign bus.m_valid    = (occ != '0);
    assign bus.m_data     = buffer[head];

    // Skid buffer: capture the returning word, pop on handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ      <= '0;
            inflight <= 1'b0;
            head     <= '0;
            tail     <= '0;
            for (int i = 0; i < int'(BUF_DEPTH); i++) begin
                buffer[i] <= '0;
            end
        end else begin
            inflight <= rd_en_c;
            if (inflight) begin
                buffer[tail] <= bus.fifo_data_out;
                tail         <= ptr_inc(tail);
            end
            if (pop_c) begin
                head <= ptr_inc(head);
            end
            case ({inflight, pop_c})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Sticky underflow flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underflow_err <= 1'b0;
        end else if (bus.fifo_underflow) begin
            underflow_err <= 1'b1;
        end
    end

`ifdef FIFO_READER_STATS_EN
    // Saturating beat and stall counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (pop_c && (beat_cnt != 16'hFFFF)) begin
                beat_cnt <= beat_cnt + 16'd1;
            end
            if (bus.m_valid && !bus.m_ready && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed testbench for fifo_stream_reader with a behavioural FIFO read port.
module tb_fifo_stream_reader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic run = 1'b0;
    logic m_ready = 1'b0;
    logic busy;
    logic underflow_err;
`ifdef FIFO_READER_STATS_EN
    logic [15:0] beat_cnt;
    logic [15:0] stall_cnt;
`endif

    int checks = 0;
    int fails  = 0;

    // Behavioural FIFO: tasks write at negedge, reads happen on posedge.
    logic [15:0] mem [4096];
    logic [11:0] wr_ptr = '0;
    logic [11:0] rd_ptr = '0;
    logic        flush = 1'b0;
    logic        mask = 1'b0;
    logic        force_uf = 1'b0;
    logic        model_uf = 1'b0;

    fifo_stream_reader_if #(.DATA_WIDTH(16)) bus ();

    assign bus.fifo_empty     = (rd_ptr == wr_ptr) || mask;
    assign bus.fifo_underflow = model_uf || force_uf;
    assign bus.m_ready        = m_ready;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (flush) begin
            rd_ptr <= wr_ptr;
        end else if (bus.fifo_rd_en && !bus.fifo_empty) begin
            bus.fifo_data_out <= mem[rd_ptr];
            rd_ptr            <= rd_ptr + 12'd1;
        end
        model_uf <= bus.fifo_rd_en && bus.fifo_empty;
    end

    fifo_stream_reader #(
        .DATA_WIDTH(16),
        .BUF_DEPTH (3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .run          (run),
        .bus          (bus),
        .busy         (busy),
        .underflow_err(underflow_err)
`ifdef FIFO_READER_STATS_EN
        ,
        .beat_cnt     (beat_cnt),
        .stall_cnt    (stall_cnt)
`endif
    );

    task automatic preload(input int n, input logic [15:0] base, input int step);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr] = base + 16'(i * step);
            wr_ptr      = wr_ptr + 12'd1;
        end
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst_n    = 1'b0;
        flush    = 1'b1;
        run      = 1'b0;
        m_ready  = 1'b0;
        mask     = 1'b0;
        force_uf = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        flush = 1'b0;
    endtask

    task automatic test_reset;
        int seen;
        @(negedge clk);
        #1;
        checks++; if (bus.m_valid !== 1'b0) begin fails++; $display("FAIL reset_m_valid: got %b expected 0", bus.m_valid); end
        checks++; if (bus.fifo_rd_en !== 1'b0) begin fails++; $display("FAIL reset_rd_en: got %b expected 0", bus.fifo_rd_en); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (underflow_err !== 1'b0) begin fails++; $display("FAIL reset_uf: got %b expected 0", underflow_err); end
        checks++; if (bus.m_data !== 16'h0000) begin fails++; $display("FAIL reset_m_data: got %h expected 0000", bus.m_data); end

        do_reset;
        preload(8, 16'h0001, 1);
        seen = 0;
        for (int c = 0; c < 10 && seen == 0; c++) begin
            @(negedge clk);
            run = 1'b1;
            #1;
            if (bus.m_valid) seen = 1;
        end
        checks++; if (seen !== 1) begin fails++; $display("FAIL midreset_wait_valid: got %0d expected 1", seen); end
        @(negedge clk);
        #1;
        checks++; if (bus.m_data !== 16'h0001) begin fails++; $display("FAIL midreset_pre_data: got %h expected 0001", bus.m_data); end
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL midreset_pre_busy: got %b expected 1", busy); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.m_valid !== 1'b0) begin fails++; $display("FAIL midreset_m_valid: got %b expected 0", bus.m_valid); end
        checks++; if (bus.fifo_rd_en !== 1'b0) begin fails++; $display("FAIL midreset_rd_en: got %b expected 0", bus.fifo_rd_en); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL midreset_busy: got %b expected 0", busy); end
        checks++; if (underflow_err !== 1'b0) begin fails++; $display("FAIL midreset_uf: got %b expected 0", underflow_err); end
        checks++; if (bus.m_data !== 16'h0000) begin fails++; $display("FAIL midreset_m_data: got %h expected 0000", bus.m_data); end
    endtask

    task automatic test_stream;
        int rd_cnt, first_rd, first_v, first_pop, last_pop, uf_seen;
        logic [15:0] got[$];
        rd_cnt = 0; first_rd = -1; first_v = -1; first_pop = -1; last_pop = -1; uf_seen = 0;
        do_reset;
        preload(8, 16'h0001, 1);
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (c == 0) begin run = 1'b1; m_ready = 1'b1; end
            #1;
            if (bus.fifo_rd_en) begin rd_cnt++; if (first_rd < 0) first_rd = c; end
            if (bus.m_valid && first_v < 0) first_v = c;
            if (bus.m_valid && m_ready) begin
                got.push_back(bus.m_data);
                if (first_pop < 0) first_pop = c;
                last_pop = c;
            end
            if (bus.fifo_underflow) uf_seen = 1;
        end
        checks++; if (rd_cnt !== 8) begin fails++; $display("FAIL stream_rd_count: got %0d expected 8", rd_cnt); end
        checks++; if (first_rd !== 1) begin fails++; $display("FAIL stream_first_rd: got %0d expected 1", first_rd); end
        checks++; if (first_v !== 3) begin fails++; $display("FAIL stream_first_valid: got %0d expected 3", first_v); end
        checks++; if (got.size() !== 8) begin fails++; $display("FAIL stream_word_count: got %0d expected 8", got.size()); end
        for (int i = 0; i < got.size() && i < 8; i++) begin
            checks++; if (got[i] !== 16'(i + 1)) begin fails++; $display("FAIL stream_word[%0d]: got %h expected %h", i, got[i], 16'(i + 1)); end
        end
        checks++; if (last_pop - first_pop !== 7) begin fails++; $display("FAIL stream_consecutive: got span %0d expected 7", last_pop - first_pop); end
        checks++; if (uf_seen !== 0) begin fails++; $display("FAIL stream_underflow: got %0d expected 0", uf_seen); end
    endtask

    task automatic test_backpressure;
        int rd_cnt, hold_bad;
        logic [15:0] got[$];
        rd_cnt = 0; hold_bad = 0;
        do_reset;
        preload(8, 16'h0001, 1);
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (c == 0) run = 1'b1;
            #1;
            if (bus.fifo_rd_en) rd_cnt++;
            if (bus.m_valid && bus.m_data !== 16'h0001) hold_bad++;
        end
        checks++; if (rd_cnt !== 3) begin fails++; $display("FAIL bp_rd_count: got %0d expected 3", rd_cnt); end
        checks++; if (hold_bad !== 0) begin fails++; $display("FAIL bp_hold: got %0d changes expected 0", hold_bad); end
        checks++; if (bus.m_valid !== 1'b1) begin fails++; $display("FAIL bp_valid: got %b expected 1", bus.m_valid); end
        checks++; if (bus.m_data !== 16'h0001) begin fails++; $display("FAIL bp_data: got %h expected 0001", bus.m_data); end
        @(negedge clk);
        #1;
`ifdef FIFO_READER_STATS_EN
        checks++; if (stall_cnt !== 16'd12) begin fails++; $display("FAIL bp_stall_cnt: got %0d expected 12", stall_cnt); end
`endif
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c == 0) m_ready = 1'b1;
            #1;
            if (bus.fifo_rd_en) rd_cnt++;
            if (bus.m_valid && m_ready) got.push_back(bus.m_data);
        end
        checks++; if (rd_cnt !== 8) begin fails++; $display("FAIL bp_rd_total: got %0d expected 8", rd_cnt); end
        checks++; if (got.size() !== 8) begin fails++; $display("FAIL bp_word_count: got %0d expected 8", got.size()); end
        for (int i = 0; i < got.size() && i < 8; i++) begin
            checks++; if (got[i] !== 16'(i + 1)) begin fails++; $display("FAIL bp_word[%0d]: got %h expected %h", i, got[i], 16'(i + 1)); end
        end
`ifdef FIFO_READER_STATS_EN
        checks++; if (beat_cnt !== 16'd8) begin fails++; $display("FAIL bp_beat_cnt: got %0d expected 8", beat_cnt); end
`endif
    endtask

    task automatic test_run_drop;
        int rd_cnt, busy_bad;
        logic [15:0] got[$];
        rd_cnt = 0; busy_bad = 0;
        do_reset;
        preload(8, 16'h0001, 1);
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (c == 0) begin run = 1'b1; m_ready = 1'b1; end
            if (c == 4) run = 1'b0;
            #1;
            if (bus.fifo_rd_en) rd_cnt++;
            if (bus.m_valid && m_ready) got.push_back(bus.m_data);
            if (c >= 1 && c <= 6 && busy !== 1'b1) busy_bad++;
        end
        checks++; if (rd_cnt !== 4) begin fails++; $display("FAIL drop_rd_count: got %0d expected 4", rd_cnt); end
        checks++; if (got.size() !== 4) begin fails++; $display("FAIL drop_word_count: got %0d expected 4", got.size()); end
        for (int i = 0; i < got.size() && i < 4; i++) begin
            checks++; if (got[i] !== 16'(i + 1)) begin fails++; $display("FAIL drop_word[%0d]: got %h expected %h", i, got[i], 16'(i + 1)); end
        end
        checks++; if (busy_bad !== 0) begin fails++; $display("FAIL drop_busy_during: got %0d idle cycles expected 0", busy_bad); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL drop_idle: got busy %b expected 0", busy); end
    endtask

    task automatic test_empty_underflow;
        int rd_cnt;
        rd_cnt = 0;
        do_reset;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c == 0) run = 1'b1;
            #1;
            if (bus.fifo_rd_en) rd_cnt++;
        end
        checks++; if (rd_cnt !== 0) begin fails++; $display("FAIL empty_rd_count: got %0d expected 0", rd_cnt); end
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL empty_busy: got %b expected 1", busy); end
        checks++; if (underflow_err !== 1'b0) begin fails++; $display("FAIL empty_uf_pre: got %b expected 0", underflow_err); end
        @(negedge clk);
        force_uf = 1'b1;
        @(negedge clk);
        force_uf = 1'b0;
        run      = 1'b0;
        #1;
        checks++; if (underflow_err !== 1'b1) begin fails++; $display("FAIL uf_set: got %b expected 1", underflow_err); end
        repeat (5) @(negedge clk);
        #1;
        checks++; if (underflow_err !== 1'b1) begin fails++; $display("FAIL uf_sticky: got %b expected 1", underflow_err); end
        rst_n = 1'b0;
        #1;
        checks++; if (underflow_err !== 1'b0) begin fails++; $display("FAIL uf_clear: got %b expected 0", underflow_err); end
    endtask

    task automatic test_random;
        int viol, rd_total, exp_idx;
        logic [15:0] exp_w;
        viol = 0; rd_total = 0; exp_idx = 0;
        do_reset;
        preload(600, 16'h0100, 37);
        for (int c = 0; c < 1010; c++) begin
            @(negedge clk);
            if (c < 1000) begin
                if (c == 0) run = 1'b1;
                mask    = (c % 2 == 1);
                m_ready = 1'($urandom_range(0, 1));
            end else begin
                run     = 1'b0;
                mask    = 1'b0;
                m_ready = 1'b1;
            end
            #1;
            if (bus.fifo_rd_en && bus.fifo_empty) viol++;
            if (bus.fifo_rd_en) rd_total++;
            if (bus.m_valid && m_ready) begin
                exp_w = 16'h0100 + 16'(exp_idx * 37);
                checks++; if (bus.m_data !== exp_w) begin fails++; $display("FAIL rand_word[%0d]: got %h expected %h", exp_idx, bus.m_data, exp_w); end
                exp_idx++;
            end
        end
        checks++; if (viol !== 0) begin fails++; $display("FAIL rand_rd_on_empty: got %0d expected 0", viol); end
        checks++; if (exp_idx !== rd_total) begin fails++; $display("FAIL rand_delivered: got %0d expected %0d", exp_idx, rd_total); end
        checks++; if (exp_idx < 100) begin fails++; $display("FAIL rand_progress: got %0d expected at least 100", exp_idx); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rand_idle: got %b expected 0", busy); end
        checks++; if (underflow_err !== 1'b0) begin fails++; $display("FAIL rand_uf: got %b expected 0", underflow_err); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_stream;
        test_backpressure;
        test_run_drop;
        test_empty_underflow;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
